// File: rtl/script_sequencer_pkg.sv
// Shared encodings for the script sequencer: opcodes, func codes, feedback indices,
// FSM states and the instruction word layout.
package script_sequencer_pkg;

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpAct  = 3'b001;
  localparam logic [2:0] OpJmp  = 3'b010;
  localparam logic [2:0] OpWait = 3'b011;
  localparam logic [2:0] OpGame = 3'b100;

  // Jump condition funcs
  localparam logic [1:0] FuncAlways = 2'b00;
  localparam logic [1:0] FuncIfSet  = 2'b01;
  localparam logic [1:0] FuncIfClr  = 2'b10;
  localparam logic [1:0] FuncNever  = 2'b11;

  // Wait funcs
  localparam logic [1:0] WaitMs  = 2'b00;
  localparam logic [1:0] WaitSet = 2'b01;
  localparam logic [1:0] WaitClr = 2'b10;

  // Feedback vector bit positions; i_sign[1:0] selects relative to FbBase
  localparam int unsigned FbBase    = 2;
  localparam int unsigned FbFront   = 2;
  localparam int unsigned FbHand    = 3;
  localparam int unsigned FbProc    = 4;
  localparam int unsigned FbMachine = 5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StAct,
    StWait,
    StAdv,
    StGate
  } state_e;

  typedef struct packed {
    logic [7:0] i_num;
    logic [2:0] i_sign;
    logic [1:0] func;
    logic [2:0] op_code;
  } insn_t;

  // Shared by jump (taken) and condition wait (satisfied).
  function automatic logic cond_eval(input logic [1:0] func, input logic c);
    logic res_v;
    unique case (func)
      FuncAlways: res_v = 1'b1;
      FuncIfSet:  res_v = c;
      FuncIfClr:  res_v = ~c;
      default:    res_v = 1'b0;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/script_sequencer_if.sv
// Bundle between the sequencer, the script ROM, kitchen feedback and the action consumer.
interface script_sequencer_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned INSN_W = 16,
  parameter int unsigned FB_W   = 8
);

  logic [INSN_W-1:0] insn;
  logic [PC_W-1:0]   pc;
  logic [FB_W-1:0]   feedback;
  logic              ms_tick;
  logic              run_en;
  logic              step_mode;
  logic              step_pulse;
  logic              act_valid;
  logic [1:0]        act_func;
  logic [7:0]        act_arg;
  logic              act_ready;
  logic [1:0]        game_state;
  logic              busy;
  logic              tmo_err;

  modport master (
    input  insn, feedback, ms_tick, run_en, step_mode, step_pulse, act_ready,
    output pc, act_valid, act_func, act_arg, game_state, busy, tmo_err
  );

  modport slave (
    output insn, feedback, ms_tick, run_en, step_mode, step_pulse, act_ready,
    input  pc, act_valid, act_func, act_arg, game_state, busy, tmo_err
  );

endinterface

// File: rtl/script_sequencer_wait_timer.sv
// Millisecond tick counter for timed and condition waits: loadable target, saturating count,
// done once the target is reached and timeout once TMO_MS ticks elapse.
module script_sequencer_wait_timer #(
  parameter int unsigned TMO_MS = 5000
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       tick_i,
  input  logic [7:0] target_i,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int unsigned CntW = (TMO_MS > 255) ? $clog2(TMO_MS + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      tgt_q, tgt_d;

  always_comb begin
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    if (load_i) begin
      cnt_d = '0;
      tgt_d = target_i;
    end else if (en_i && tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      cnt_q <= '0;
      tgt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

  assign done_o    = (cnt_q >= CntW'(tgt_q));
  assign timeout_o = (TMO_MS != 0) && (cnt_q >= CntW'(TMO_MS));

endmodule

// File: rtl/script_sequencer.sv
// Script executor: fetches words from a 1-cycle sync ROM and dispatches action, jump,
// wait and game-state instructions under run/step control.
module script_sequencer
  import script_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned PC_STEP = 2,
  parameter int unsigned INSN_W  = 16,
  parameter int unsigned FB_W    = 8,
  parameter int unsigned TMO_MS  = 5000
) (
  input logic               clk,
  input logic               res,
  script_sequencer_if.master bus
);

  localparam int unsigned FbIdxW = (FB_W > 1) ? $clog2(FB_W) : 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic            act_valid_q, act_valid_d;
  logic [1:0]      act_func_q, act_func_d;
  logic [7:0]      act_arg_q, act_arg_d;
  logic [1:0]      game_q, game_d;
  logic            tmo_q, tmo_d;
  logic [1:0]      wfunc_q, wfunc_d;
  logic [1:0]      sel_q, sel_d;

  insn_t             ins;
  logic              unused_sign_msb;
  logic [1:0]        sel;
  logic [FbIdxW-1:0] fb_idx;
  logic              cond;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jmp_tgt;
  logic              tmr_load, tmr_en, tmr_done, tmr_tmo;

  assign ins             = insn_t'(bus.insn[15:0]);
  assign unused_sign_msb = ins.i_sign[2];

  // Jump/wait decisions in DECODE use the fresh word; WAIT re-evaluates with the latched select.
  assign sel     = (state_q == StDecode) ? ins.i_sign[1:0] : sel_q;
  assign fb_idx  = FbIdxW'(sel) + FbIdxW'(FbBase);
  assign cond    = bus.feedback[fb_idx];
  assign pc_inc  = pc_q + PC_W'(PC_STEP);
  assign jmp_tgt = PC_W'(ins.i_num) & ~PC_W'(PC_STEP - 1);

  script_sequencer_wait_timer #(
    .TMO_MS (TMO_MS)
  ) u_wait_timer (
    .clk_i     (clk),
    .res_i     (res),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .tick_i    (bus.ms_tick),
    .target_i  (ins.i_num),
    .done_o    (tmr_done),
    .timeout_o (tmr_tmo)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    act_valid_d = act_valid_q;
    act_func_d  = act_func_q;
    act_arg_d   = act_arg_q;
    game_d      = game_q;
    tmo_d       = tmo_q;
    wfunc_d     = wfunc_q;
    sel_d       = sel_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.run_en) state_d = StFetch;
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        npc_d   = pc_inc;
        state_d = StAdv;
        case (ins.op_code)
          OpAct: begin
            act_valid_d = 1'b1;
            act_func_d  = ins.func;
            act_arg_d   = ins.i_num;
            state_d     = StAct;
          end
          OpJmp: begin
            if (cond_eval(ins.func, cond)) npc_d = jmp_tgt;
          end
          OpWait: begin
            wfunc_d  = ins.func;
            sel_d    = ins.i_sign[1:0];
            tmr_load = 1'b1;
            state_d  = StWait;
          end
          OpGame: begin
            game_d = ins.func;
          end
          default: ;
        endcase
      end
      StAct: begin
        if (bus.act_ready) begin
          act_valid_d = 1'b0;
          state_d     = StAdv;
        end
      end
      StWait: begin
        tmr_en = 1'b1;
        case (wfunc_q)
          WaitMs: begin
            if (tmr_done) state_d = StAdv;
          end
          WaitSet, WaitClr: begin
            if (cond_eval(wfunc_q, cond)) begin
              state_d = StAdv;
            end else if (tmr_tmo) begin
              tmo_d   = 1'b1;
              state_d = StAdv;
            end
          end
          default: state_d = StAdv;
        endcase
      end
      StAdv: begin
        pc_d    = npc_q;
        state_d = StGate;
      end
      StGate: begin
        if (!bus.run_en) begin
          state_d = StIdle;
        end else if (!bus.step_mode || bus.step_pulse) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      npc_q       <= '0;
      act_valid_q <= 1'b0;
      act_func_q  <= '0;
      act_arg_q   <= '0;
      game_q      <= '0;
      tmo_q       <= 1'b0;
      wfunc_q     <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      act_valid_q <= act_valid_d;
      act_func_q  <= act_func_d;
      act_arg_q   <= act_arg_d;
      game_q      <= game_d;
      tmo_q       <= tmo_d;
      wfunc_q     <= wfunc_d;
      sel_q       <= sel_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.act_valid  = act_valid_q;
  assign bus.act_func   = act_func_q;
  assign bus.act_arg    = act_arg_q;
  assign bus.game_state = game_q;
  assign bus.tmo_err    = tmo_q;
  assign bus.busy       = (state_q != StIdle) && (state_q != StGate);

endmodule
